// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next control store address from the microinstruction
// condition field. Optional call/return stack enabled with the MPC_STACK_EN macro.
module micro_sequencer #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned FETCH_ADDR    = 0,
    parameter int unsigned DISPATCH_BASE = 0,
    parameter int unsigned STACK_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [7:0]                         ins_in,
    input  logic                               z_flag,
    input  logic [2:0]                         mi_cond,
    input  logic [ADDR_W-1:0]                  mi_addr,
    output logic [ADDR_W-1:0]                  mpc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               seq_err
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] CondInc      = 3'd0;
    localparam logic [2:0] CondJmp      = 3'd1;
    localparam logic [2:0] CondJz       = 3'd2;
    localparam logic [2:0] CondJnz      = 3'd3;
    localparam logic [2:0] CondDispatch = 3'd4;
    localparam logic [2:0] CondFetch    = 3'd5;
    localparam logic [2:0] CondCall     = 3'd6;
    localparam logic [2:0] CondRet      = 3'd7;

    localparam logic [ADDR_W-1:0] FetchAddr = ADDR_W'(FETCH_ADDR);

    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [ADDR_W-1:0] mpc_inc;
    logic [ADDR_W-1:0] dispatch_addr;

    assign mpc_inc       = mpc_q + ADDR_W'(1);
    assign dispatch_addr = ADDR_W'(ins_in) + ADDR_W'(DISPATCH_BASE);

`ifdef MPC_STACK_EN
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;
    logic              push;
    logic              full, empty;
    logic [IDX_W-1:0]  push_idx, pop_idx;

    assign full     = (level_q == LVL_W'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    assign push_idx = IDX_W'(level_q);
    assign pop_idx  = IDX_W'(level_q - LVL_W'(1));
`endif

    always_comb begin
        mpc_d = mpc_q;
`ifdef MPC_STACK_EN
        level_d = level_q;
        err_d   = err_q;
        push    = 1'b0;
`endif
        if (!stall) begin
            // z_flag and ins_in are only looked at inside their own arms.
            unique case (mi_cond)
                CondInc:      mpc_d = mpc_inc;
                CondJmp:      mpc_d = mi_addr;
                CondJz:       mpc_d = z_flag ? mi_addr : mpc_inc;
                CondJnz:      mpc_d = z_flag ? mpc_inc : mi_addr;
                CondDispatch: mpc_d = dispatch_addr;
                CondFetch:    mpc_d = FetchAddr;
`ifdef MPC_STACK_EN
                CondCall: begin
                    mpc_d = mi_addr;
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        level_d = level_q + LVL_W'(1);
                    end
                end
                CondRet: begin
                    if (empty) begin
                        mpc_d = FetchAddr;
                        err_d = 1'b1;
                    end else begin
                        mpc_d   = stack_q[pop_idx];
                        level_d = level_q - LVL_W'(1);
                    end
                end
`else
                CondCall:     mpc_d = mpc_inc;
                CondRet:      mpc_d = mpc_inc;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpc_q <= FetchAddr;
        end else begin
            mpc_q <= mpc_d;
        end
    end

`ifdef MPC_STACK_EN
    // Stack contents need no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= mpc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    assign stack_level = level_q;
    assign seq_err     = err_q;
`else
    assign stack_level = '0;
    assign seq_err     = 1'b0;
`endif

    assign mpc = mpc_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: vector table plus hand-written stack/reset sequences,
// with expected results queued when stimulus is driven and checked one cycle later.
module tb_micro_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             stall;
        logic [7:0]       ins;
        logic             z;
        logic [2:0]       cond;
        logic [7:0]       addr;
        logic [7:0]       exp_mpc;
        logic [LVL_W-1:0] exp_lvl;
        logic             exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic [7:0]       ins_in = 8'h00;
    logic             z_flag = 1'b0;
    logic [2:0]       mi_cond = 3'd0;
    logic [7:0]       mi_addr = 8'h00;
    logic [7:0]       mpc;
    logic [LVL_W-1:0] stack_level;
    logic             seq_err;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tag = 0;
    vec_t exp_q[$];
    vec_t vecs[17];

    micro_sequencer #(
        .ADDR_W       (ADDR_W),
        .FETCH_ADDR   (0),
        .DISPATCH_BASE(32'h20),
        .STACK_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ins_in     (ins_in),
        .z_flag     (z_flag),
        .mi_cond    (mi_cond),
        .mi_addr    (mi_addr),
        .mpc        (mpc),
        .stack_level(stack_level),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [7:0] ins, input logic z,
                                input logic [2:0] cond, input logic [7:0] addr,
                                input logic [7:0] em, input logic [LVL_W-1:0] el,
                                input logic ee);
        vec_t v;
        v.stall = st; v.ins = ins; v.z = z; v.cond = cond; v.addr = addr;
        v.exp_mpc = em; v.exp_lvl = el; v.exp_err = ee;
        return v;
    endfunction

    task automatic check_now(input string name, input logic [7:0] em,
                             input logic [LVL_W-1:0] el, input logic ee);
        n_checks++;
        if (mpc !== em) begin
            n_fail++;
            $display("FAIL %s mpc: got %h expected %h", name, mpc, em);
        end
        n_checks++;
        if (stack_level !== el) begin
            n_fail++;
            $display("FAIL %s stack_level: got %0d expected %0d", name, stack_level, el);
        end
        n_checks++;
        if (seq_err !== ee) begin
            n_fail++;
            $display("FAIL %s seq_err: got %b expected %b", name, seq_err, ee);
        end
    endtask

    // Drive one microinstruction, queue its expectation, then check after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        stall   = v.stall;
        ins_in  = v.ins;
        z_flag  = v.z;
        mi_cond = v.cond;
        mi_addr = v.addr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tag++;
        check_now($sformatf("step%0d", tag), e.exp_mpc, e.exp_lvl, e.exp_err);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        check_now("async_reset", 8'h00, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Unused z/ins fields carry values that would change mpc if wrongly consulted.
        vecs[0]  = mk(0, 8'hAA, 1, 3'd0, 8'hEE, 8'h01, 0, 0);
        vecs[1]  = mk(0, 8'hAA, 1, 3'd0, 8'hEE, 8'h02, 0, 0);
        vecs[2]  = mk(0, 8'hAA, 0, 3'd0, 8'hEE, 8'h03, 0, 0);
        vecs[3]  = mk(0, 8'hAA, 1, 3'd1, 8'h10, 8'h10, 0, 0);
        vecs[4]  = mk(0, 8'hAA, 1, 3'd2, 8'h40, 8'h40, 0, 0);
        vecs[5]  = mk(0, 8'hAA, 0, 3'd1, 8'h10, 8'h10, 0, 0);
        vecs[6]  = mk(0, 8'hAA, 0, 3'd2, 8'h40, 8'h11, 0, 0);
        vecs[7]  = mk(0, 8'hAA, 0, 3'd3, 8'h40, 8'h40, 0, 0);
        vecs[8]  = mk(0, 8'hAA, 1, 3'd3, 8'h55, 8'h41, 0, 0);
        vecs[9]  = mk(0, 8'h05, 1, 3'd4, 8'hEE, 8'h25, 0, 0);
        vecs[10] = mk(0, 8'hF0, 1, 3'd4, 8'hEE, 8'h10, 0, 0);
        vecs[11] = mk(0, 8'hAA, 1, 3'd5, 8'hEE, 8'h00, 0, 0);
        vecs[12] = mk(0, 8'hAA, 1, 3'd1, 8'hFF, 8'hFF, 0, 0);
        vecs[13] = mk(0, 8'hAA, 1, 3'd0, 8'hEE, 8'h00, 0, 0);
        vecs[14] = mk(0, 8'hAA, 1, 3'd1, 8'h33, 8'h33, 0, 0);
        vecs[15] = mk(1, 8'hAA, 1, 3'd1, 8'h77, 8'h33, 0, 0);
        vecs[16] = mk(0, 8'hAA, 1, 3'd1, 8'h77, 8'h77, 0, 0);

        // Reset state, then a reset asserted mid-run.
        @(posedge clk);
        #1;
        check_now("reset_state", 8'h00, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(mk(0, 8'hAA, 1, 3'd0, 8'hEE, 8'h01, 0, 0));
        step(mk(0, 8'hAA, 1, 3'd1, 8'h99, 8'h99, 0, 0));
        do_reset();
        #1;
        check_now("after_reset", 8'h00, '0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            if (i == 15) begin
                for (int k = 0; k < 4; k++) step(vecs[15]);
            end else begin
                step(vecs[i]);
            end
        end

`ifdef MPC_STACK_EN
        step(mk(0, 8'hAA, 1, 3'd1, 8'h08, 8'h08, 0, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h50, 8'h50, 1, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h60, 8'h60, 2, 0));
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h51, 1, 0));
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h09, 0, 0));
        // Five nested calls: the fifth overflows.
        step(mk(0, 8'hAA, 1, 3'd6, 8'h80, 8'h80, 1, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h81, 8'h81, 2, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h82, 8'h82, 3, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h83, 8'h83, 4, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h84, 8'h84, 4, 1));
        step(mk(1, 8'hAA, 1, 3'd7, 8'hEE, 8'h84, 4, 1));
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h83, 3, 1));
        do_reset();
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h00, 0, 1));
        step(mk(0, 8'hAA, 1, 3'd0, 8'hEE, 8'h01, 0, 1));
        do_reset();
`else
        step(mk(0, 8'hAA, 1, 3'd1, 8'h08, 8'h08, 0, 0));
        step(mk(0, 8'hAA, 1, 3'd6, 8'h50, 8'h09, 0, 0));
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h0A, 0, 0));
        step(mk(0, 8'hAA, 1, 3'd7, 8'hEE, 8'h0B, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
